// File: rtl/latch_sr_pkg.sv
// latch_sr_pkg: set/reset priority constants, legal synchronizer depths and the shared next-state rule
package latch_sr_pkg;
  localparam bit PRIO_RESET = 1'b0;
  localparam bit PRIO_SET = 1'b1;
  localparam int SYNC_NONE = 0;
  localparam int SYNC_2FF = 2;
  localparam int SYNC_3FF = 3;
  function automatic bit sync_ok(int n);
    return n == SYNC_NONE || n == SYNC_2FF || n == SYNC_3FF;
  endfunction
  function automatic logic next_q(logic q, logic s, logic r, logic set_dom);
    return (s & r) ? set_dom : s ? 1'b1 : r ? 1'b0 : q;
  endfunction
endpackage

// File: rtl/latch_sr_sync.sv
// latch_sr_sync: per-bit STAGES-flop shift chain (clk, rst_n sync active-low clears to 0, d in, q out)
module latch_sr_sync #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] chain [STAGES];
  always_ff @(posedge clk) begin
    if (!rst_n) chain <= '{default: '0};
    else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end
  assign q = chain[STAGES-1];
endmodule

// File: rtl/latch_sr.sv
// latch_sr: registered per-channel SR element (clk, rst_n sync active-low, s/r requests in; q, q_n, conflict out)
module latch_sr
  import latch_sr_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter bit SET_DOMINANT = PRIO_RESET,
  parameter int SYNC_STAGES = SYNC_NONE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] conflict
);
  logic [WIDTH-1:0] s_i, r_i, q_d;
  if (!sync_ok(SYNC_STAGES)) begin : g_bad
    $error("latch_sr: SYNC_STAGES must be 0, 2 or 3");
  end
  if (SYNC_STAGES > 0) begin : g_sync
    latch_sr_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_s (.clk(clk), .rst_n(rst_n), .d(s), .q(s_i));
    latch_sr_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_r (.clk(clk), .rst_n(rst_n), .d(r), .q(r_i));
  end else begin : g_raw
    assign s_i = s;
    assign r_i = r;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    assign q_d[i] = next_q(q[i], s_i[i], r_i[i], SET_DOMINANT);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
      q_n <= '1;
      conflict <= '0;
    end else begin
      q <= q_d;
      q_n <= ~q_d;
      conflict <= s_i & r_i;
    end
  end
endmodule

// File: tb/tb_latch_sr.sv
// tb_latch_sr: directed and random stimulus on three latch_sr configurations against a boolean reference model
module tb_latch_sr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s0 = 1'b0, r0 = 1'b0;
  logic [3:0] s2 = '0, r2 = '0;
  logic q0, qn0, c0, q1, qn1, c1;
  logic [3:0] q2, qn2, c2;
  logic [3:0] m0, m1, m2, k0, k1, k2;
  logic [3:0] hs0, hs1, hr0, hr1;
  int n_checks = 0, n_fail = 0;

  latch_sr #(.WIDTH(1), .SET_DOMINANT(1'b0), .SYNC_STAGES(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .s(s0), .r(r0), .q(q0), .q_n(qn0), .conflict(c0));
  latch_sr #(.WIDTH(1), .SET_DOMINANT(1'b1), .SYNC_STAGES(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .s(s0), .r(r0), .q(q1), .q_n(qn1), .conflict(c1));
  latch_sr #(.WIDTH(4), .SET_DOMINANT(1'b0), .SYNC_STAGES(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .s(s2), .r(r2), .q(q2), .q_n(qn2), .conflict(c2));

  always #5 clk = ~clk;

  function automatic logic [3:0] rule(logic [3:0] q, logic [3:0] s, logic [3:0] r, logic sd);
    return (s & ~r) | (s & r & {4{sd}}) | (~s & ~r & q);
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic a, input logic b, input logic [3:0] c, input logic [3:0] d);
    rst_n = rn;
    s0 = a;
    r0 = b;
    s2 = c;
    r2 = d;
    @(posedge clk);
    if (!rn) begin
      {m0, m1, m2, k0, k1, k2} = '0;
      {hs0, hs1, hr0, hr1} = '0;
    end else begin
      m0 = rule(m0, {3'b0, a}, {3'b0, b}, 1'b0);
      m1 = rule(m1, {3'b0, a}, {3'b0, b}, 1'b1);
      k0 = {3'b0, a & b};
      k1 = k0;
      m2 = rule(m2, hs1, hr1, 1'b0);
      k2 = hs1 & hr1;
      hs1 = hs0;
      hr1 = hr0;
      hs0 = c;
      hr0 = d;
    end
    #1;
    chk("q0", {3'b0, q0}, m0);
    chk("qn0", {3'b0, qn0}, {3'b0, ~m0[0]});
    chk("conflict0", {3'b0, c0}, k0);
    chk("q1", {3'b0, q1}, m1);
    chk("qn1", {3'b0, qn1}, {3'b0, ~m1[0]});
    chk("conflict1", {3'b0, c1}, k1);
    chk("q2", q2, m2);
    chk("qn2", qn2, ~m2);
    chk("conflict2", c2, k2);
  endtask

  initial begin
    logic [1:0] p;
    {m0, m1, m2, k0, k1, k2} = '0;
    {hs0, hs1, hr0, hr1} = '0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    chk("reset_hold_q", {3'b0, q0}, 4'h0);
    step(1, 1, 0, 0, 0);
    chk("set_q", {3'b0, q0}, 4'h1);
    step(1, 0, 0, 0, 0);
    chk("hold_q", {3'b0, q0}, 4'h1);
    step(1, 0, 1, 0, 0);
    chk("clear_q", {3'b0, q0}, 4'h0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("conflict_rdom", {2'b0, q0, c0}, 4'b0001);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("conflict_sdom", {2'b0, q1, c1}, 4'b0011);
    step(1, 0, 0, 0, 0);
    chk("conflict_drop", {2'b0, q1, c1}, 4'b0010);
    for (int rep = 0; rep < 3; rep++)
      for (int j = 0; j < 4; j++) begin
        p = 2'(j);
        step(1, p[1], p[0], 0, 0);
      end
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("midop_reset", {3'b0, q0}, 4'h0);
    step(1, 1, 0, 0, 0);
    chk("midop_resume", {3'b0, q0}, 4'h1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 4'b0101, 0);
    step(1, 0, 0, 0, 0);
    chk("sync_early", q2, 4'b0000);
    step(1, 0, 0, 0, 0);
    chk("sync_q", q2, 4'b0101);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 4'b0001);
    chk("sync_clear", q2, 4'b0100);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
